// File: rtl/pipeline_pkg.sv
// Shared definitions for the add/subtract pipeline: operation codes and count sizing.
package pipeline_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Bits needed to hold an occupancy count of 0..depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline slot: a valid bit plus a data register that loads on enable.
module pipe_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          load,
    input  logic          vld_in,
    input  logic [DW-1:0] d,
    output logic          vld,
    output logic [DW-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
            q   <= '0;
        end else begin
            if (flush)
                vld <= 1'b0;
            else if (load)
                vld <= vld_in;
            // Data only moves with a real beat; empty loads leave it untouched.
            if (load && vld_in)
                q <= d;
        end
    end

endmodule

// File: rtl/pipeline_addsub.sv
// Elastic add/subtract pipeline: stage 1 registers operands, stage 2 computes,
// later stages carry the result; empty stages fill even while the output stalls.
module pipeline_addsub
    import pipeline_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
    input  logic                    sub,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH:0]          result,
    output logic [cnt_w(DEPTH)-1:0] count
);

    localparam int RW = WIDTH + 1;

    typedef struct packed {
        op_e              op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } opnd_t;

    logic [DEPTH-1:0]           vld_pipe;
    logic [DEPTH-1:0]           load;
    opnd_t                      opnd_q;
    logic [DEPTH-1:1][RW-1:0]   res_d;
    logic [DEPTH-1:1][RW-1:0]   res_q;
    logic                       acc;
    logic                       del;

    // Walk back from the output: a stage can load when it is empty or the
    // stage behind it (toward the output) can take its contents.
    always_comb begin
        logic go;
        go   = out_ready;
        load = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            load[i] = ~vld_pipe[i] | go;
            go      = load[i];
        end
    end

    assign in_ready  = load[0] & ~flush;
    assign out_valid = vld_pipe[DEPTH-1];
    assign result    = res_q[DEPTH-1];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_opnd
            pipe_stage #(.DW($bits(opnd_t))) u_stage (
                .clk    (clk),
                .rst_n  (rst_n),
                .flush  (flush),
                .load   (load[0]),
                .vld_in (in_valid),
                .d      (opnd_t'{op: op_e'(sub), a: a, b: b}),
                .vld    (vld_pipe[0]),
                .q      (opnd_q)
            );
        end else begin : g_res
            if (i == 1) begin : g_calc
                // Zero-extended operands: bit WIDTH becomes carry or borrow.
                assign res_d[1] = (opnd_q.op == OP_SUB)
                                ? ({1'b0, opnd_q.a} - {1'b0, opnd_q.b})
                                : ({1'b0, opnd_q.a} + {1'b0, opnd_q.b});
            end else begin : g_carry
                assign res_d[i] = res_q[i-1];
            end
            pipe_stage #(.DW(RW)) u_stage (
                .clk    (clk),
                .rst_n  (rst_n),
                .flush  (flush),
                .load   (load[i]),
                .vld_in (vld_pipe[i-1]),
                .d      (res_d[i]),
                .vld    (vld_pipe[i]),
                .q      (res_q[i])
            );
        end
    end

    assign acc = in_valid & in_ready;
    assign del = out_valid & out_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (flush)
            count <= '0;
        else if (acc && !del)
            count <= count + 1'b1;
        else if (del && !acc)
            count <= count - 1'b1;
    end

endmodule

// File: tb/tb_pipeline_addsub.sv
// Directed plus randomized bench for pipeline_addsub against an occupancy/queue model.
module tb_pipeline_addsub;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int CW    = pipeline_pkg::cnt_w(DEPTH);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             sub = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH:0]   result;
    logic [CW-1:0]    count;

    always #5 clk = ~clk;

    pipeline_addsub #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .count     (count)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model: in-flight beats in order, each with the stage it occupies (1..DEPTH).
    logic [WIDTH:0] q_val[$];
    int             q_stg[$];

    function automatic logic [WIDTH:0] ref_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                              input logic s);
        bit [65:0] ax, by, m;
        ax = 66'(x);
        by = 66'(y);
        m  = 66'd1 << (WIDTH + 1);
        if (!s) return (WIDTH+1)'(ax + by);
        return (WIDTH+1)'((ax >= by) ? (ax - by) : (m + ax - by));
    endfunction

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic cyc(input bit iv, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input bit sv, input bit ordy, input bit fl);
        bit exp_ir, exp_ov, acc, del;
        in_valid = iv; a = av; b = bv; sub = sv; out_ready = ordy; flush = fl;
        #1;
        exp_ov = (q_val.size() > 0) && (q_stg[0] == DEPTH);
        exp_ir = !fl && ((q_val.size() < DEPTH) || ordy);
        chk("in_ready", 66'(in_ready), 66'(exp_ir));
        chk("out_valid", 66'(out_valid), 66'(exp_ov));
        chk("count", 66'(count), 66'(q_val.size()));
        if (exp_ov) chk("result", 66'(result), 66'(q_val[0]));
        acc = iv && exp_ir;
        del = exp_ov && ordy && !fl;
        @(posedge clk);
        if (fl) begin
            q_val.delete();
            q_stg.delete();
        end else begin
            if (del) begin
                void'(q_val.pop_front());
                void'(q_stg.pop_front());
            end
            foreach (q_stg[i])
                q_stg[i] = (q_stg[i] + 1 < DEPTH - i) ? q_stg[i] + 1 : DEPTH - i;
            if (acc) begin
                q_val.push_back(ref_op(av, bv, sv));
                q_stg.push_back(1);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int k = 0; k < n; k++) cyc(1'b0, '0, '0, 1'b0, ordy, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 4 * DEPTH + 20 && q_val.size() > 0; k++) idle(1, 1'b1);
        chk("drained_count", 66'(count), 66'd0);
    endtask

    initial begin
        // Reset state, checked while reset is held
        #1;
        chk("rst_in_ready", 66'(in_ready), 66'd1);
        chk("rst_out_valid", 66'(out_valid), 66'd0);
        chk("rst_count", 66'(count), 66'd0);
        chk("rst_result", 66'(result), 66'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 200 + 100 add, latency DEPTH
        cyc(1'b1, WIDTH'(200), WIDTH'(100), 1'b0, 1'b1, 1'b0);
        idle(DEPTH - 2, 1'b1);
        chk("lat_early_ov", 66'(out_valid), 66'd0);
        idle(1, 1'b1);
        chk("lat_ov", 66'(out_valid), 66'd1);
        chk("add_300", 66'(result), 66'h12C);
        idle(1, 1'b1);

        // Subtract with and without borrow
        cyc(1'b1, WIDTH'(5), WIDTH'(10), 1'b1, 1'b1, 1'b0);
        cyc(1'b1, WIDTH'(10), WIDTH'(5), 1'b1, 1'b1, 1'b0);
        idle(DEPTH - 2, 1'b1);
        chk("sub_borrow", 66'(result), (66'd1 << (WIDTH + 1)) - 66'd5);
        idle(1, 1'b1);
        chk("sub_pos", 66'(result), 66'd5);
        drain();

        // Back-to-back stream of 8 beats
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, WIDTH'($urandom()), WIDTH'($urandom()), 1'($urandom()), 1'b1, 1'b0);
            if (i + 1 >= DEPTH) chk("stream_count", 66'(count), 66'(DEPTH));
        end
        drain();

        // Output stall after 5 offers, then release
        for (int i = 0; i < 5; i++)
            cyc(1'b1, WIDTH'($urandom()), WIDTH'($urandom()), 1'($urandom()), 1'b0, 1'b0);
        in_valid = 1'b1; out_ready = 1'b0;
        #1;
        chk("stall_count", 66'(count), 66'(DEPTH));
        chk("stall_in_ready", 66'(in_ready), 66'd0);
        idle(2, 1'b0);
        drain();

        // Flush with two beats in flight and a beat on offer
        cyc(1'b1, WIDTH'(7), WIDTH'(9), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, WIDTH'(8), WIDTH'(3), 1'b1, 1'b0, 1'b0);
        chk("pre_flush_count", 66'(count), 66'd2);
        cyc(1'b1, WIDTH'(1), WIDTH'(1), 1'b0, 1'b1, 1'b1);
        chk("flush_count", 66'(count), 66'd0);
        chk("flush_out_valid", 66'(out_valid), 66'd0);
        idle(DEPTH + 1, 1'b1);

        // Randomized traffic with occasional flush
        for (int i = 0; i < 300; i++)
            cyc(($urandom_range(0, 3) != 0), WIDTH'($urandom()), WIDTH'($urandom()), 1'($urandom()),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
        drain();

        // Asynchronous reset between edges with a full pipeline
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b1, WIDTH'($urandom()), WIDTH'($urandom()), 1'($urandom()), 1'b0, 1'b0);
        chk("pre_rst_count", 66'(count), 66'(DEPTH));
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 66'(out_valid), 66'd0);
        chk("arst_count", 66'(count), 66'd0);
        chk("arst_result", 66'(result), 66'd0);
        chk("arst_in_ready", 66'(in_ready), 66'd1);
        q_val.delete();
        q_stg.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, WIDTH'(200), WIDTH'(100), 1'b0, 1'b1, 1'b0);
        idle(DEPTH - 1, 1'b1);
        chk("post_rst_add", 66'(result), 66'h12C);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
